fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter BUF_DEPTH, 2, instruction buffer entries; only the value 2 is supported.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 imem_req  output  1  fetch request valid.
REQ-007 imem_addr  output  32  fetch address, word-aligned.
REQ-008 imem_gnt  input  1  request accepted this cycle.
REQ-009 imem_rvalid  input  1  response data valid.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 redirect  input  1  branch or PC write taken; the PCS path after the condition check.
REQ-012 redirect_pc  input  32  new fetch address.
REQ-013 instr_valid  output  1  buffer head valid toward the decode stage.
REQ-014 instr_ready  input  1  decode stage accepts the head.
REQ-015 instr  output  32  instruction; decode takes Op=[27:26], Funct=[25:20], Rd=[15:12].
REQ-016 instr_pc  output  32  address of instr.
REQ-017 instr_pc8  output  32  instr_pc+8, the architectural PC read value.

Function
REQ-018 FSM states: FETCH (no request outstanding), WAIT (one request outstanding), DROP (outstanding response to be discarded).
REQ-019 At most one request is outstanding at any time.
REQ-020 imem_req = 1 in FETCH only when buffer count plus outstanding < BUF_DEPTH and redirect = 0; otherwise imem_req = 0.
REQ-021 imem_addr = fetch_pc; fetch_pc[1:0] is always 0.
REQ-022 On imem_req and imem_gnt: fetch_pc += 4, modulo 2^32, with wrap from FFFF_FFFC to 0; FSM goes to WAIT.
REQ-023 In WAIT, on imem_rvalid: push {imem_rdata, issued address} into the buffer; FSM goes to FETCH.
REQ-024 In DROP, on imem_rvalid: discard the response; FSM goes to FETCH.
REQ-025 imem_rvalid in FETCH is ignored.
REQ-026 Response-to-instr_valid latency is one cycle; there is no combinational bypass.
REQ-027 instr_valid = buffer not empty; the buffer pops when instr_valid and instr_ready.
REQ-028 Outputs hold stable while instr_valid = 1 and instr_ready = 0.
REQ-029 On redirect the buffer flushes that cycle, instr_valid = 0 next cycle, and fetch_pc <= {redirect_pc[31:2], 2'b00}.
REQ-030 If redirect arrives in WAIT without rvalid, the FSM goes to DROP.
REQ-031 If redirect arrives in WAIT with rvalid, the data is discarded and the FSM goes to FETCH.
REQ-032 If redirect arrives in DROP without rvalid, the FSM stays in DROP; with rvalid it goes to FETCH.
REQ-033 Redirect has priority over pop and push in the same cycle.
REQ-034 Simultaneous push and pop keeps the count unchanged; the buffer never overflows because of REQ-020.

Reset
REQ-035 While reset = 0: imem_req = 0, instr_valid = 0, FSM = FETCH, fetch_pc = RESET_PC, buffer empty.
REQ-036 Reset asserted mid-WAIT abandons the request; a late rvalid arriving after reset is ignored under REQ-025.
REQ-037 The first imem_req is driven in the first cycle after reset deasserts.

Structure
REQ-038 fetch_state_t, the BUF_DEPTH default and the RESET_PC default live in the shared package cpu_pkg.
REQ-039 The buffer is implemented in sub-module fetch_buffer: a 2-entry FIFO of {instr, pc} with flush, push, pop and count.

Verification
REQ-040 Reset release, gnt = 1 always, rvalid one cycle after gnt, ready = 1 -> addresses 0, 4, 8 issued; instr_pc 0, 4, 8; instr_pc8 8, 12, 16.
REQ-041 ready = 0 for 6 cycles -> two entries buffered, imem_req = 0, outputs stable; ready = 1 -> entries drain in order with no loss.
REQ-042 Redirect to 0x0000_0103 in WAIT, rvalid two cycles later -> response dropped; the next imem_addr = 0x100; the first instr_pc after redirect = 0x100.
REQ-043 Redirect in the same cycle as rvalid -> data discarded, buffer empty next cycle, fetch resumes at the target.
REQ-044 fetch_pc = 0xFFFF_FFFC, granted -> the next imem_addr = 0x0000_0000.
REQ-045 reset asserted in WAIT, rvalid during reset and one cycle after release -> no instr_valid from stale data; the first fetch is at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, buffer entry layout and
// the fetch unit's default parameters.
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   localparam int          BUF_DEPTH_DEF = 2;
   localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory port, redirect input and the
// decode-side valid/ready stream.
interface fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc8;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc8,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pc8,
      output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {instr, pc} between fetch and decode; flush wins over
// push/pop, and the caller guarantees no push when full or pop when empty.
module fetch_buffer
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t din,
   output fetch_entry_t dout,
   output logic [1:0]   count
);
   fetch_entry_t mem [2];
   logic         wr_ptr, rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Storage is data-only; validity is tracked entirely by count.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, a 2-entry instruction
// buffer toward decode, and redirect handling that drops in-flight data.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = BUF_DEPTH_DEF  // only 2 is supported
) (
   input logic          clk,
   input logic          reset,
   fetch_unit_if.master bus
);
   localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

   fetch_state_t state, state_nxt;
   logic [31:0]  fetch_pc, issue_pc;
   logic [1:0]   count;
   logic         req, push, pop, valid;
   fetch_entry_t head, wr_entry;
   logic         unused_lsb;

   assign unused_lsb = ^bus.redirect_pc[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH:   if (req && bus.imem_gnt) state_nxt = WAIT;
         WAIT:    if (bus.imem_rvalid)     state_nxt = FETCH;
                  else if (bus.redirect)   state_nxt = DROP;
         DROP:    if (bus.imem_rvalid)     state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   // Request is gated by the reset input so it is low throughout reset and
   // rises in the very first cycle after release.
   always_comb begin
      req  = 1'b0;
      push = 1'b0;
      pop  = 1'b0;
      if (state == FETCH)
         req = reset && !bus.redirect && (count < DEPTH);
      if (state == WAIT)
         push = bus.imem_rvalid && !bus.redirect;
      pop = valid && bus.instr_ready && !bus.redirect;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= {RESET_PC[31:2], 2'b00};
         issue_pc <= {RESET_PC[31:2], 2'b00};
      end else if (bus.redirect) begin
         fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
      end else if (req && bus.imem_gnt) begin
         issue_pc <= fetch_pc;
         fetch_pc <= fetch_pc + 32'd4;
      end
   end

   assign wr_entry = '{instr: bus.imem_rdata, pc: issue_pc};

   fetch_buffer u_buf (
      .clk   (clk),
      .reset (reset),
      .flush (bus.redirect),
      .push  (push),
      .pop   (pop),
      .din   (wr_entry),
      .dout  (head),
      .count (count)
   );

   assign valid         = (count != 2'd0);
   assign bus.imem_req  = req;
   assign bus.imem_addr = fetch_pc;
   assign bus.instr_valid = valid;
   assign bus.instr     = head.instr;
   assign bus.instr_pc  = head.pc;
   assign bus.instr_pc8 = head.pc + 32'd8;

endmodule
